// File: rtl/rv_pkg.sv
// Shared definitions for the pipelined core's register file: default sizes,
// register-address type and the hardwired-zero register index.
package rv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] regaddr_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: allocate at issue, clear on writeback, flush all.
// Also keeps a registered population count of the busy vector.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic          wr0_en,
  input  logic [AW-1:0] wr0_addr,
  input  logic          wr1_en,
  input  logic [AW-1:0] wr1_addr,
  input  logic          flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]   busy_count
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  // flush > alloc > write-clear > hold
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (alloc_en && alloc_addr == AW'(r) &&
                   !(ZERO_REG != 0 && r == int'(REG_ZERO))) begin
        busy_d[r] = 1'b1;
      end else if ((wr0_en && wr0_addr == AW'(r)) || (wr1_en && wr1_addr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      count_d = count_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy       = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with two prioritised write ports, optional
// write-through bypass and a busy scoreboard for issue hazard checks.
module reg_file_sb
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 wr0_en,
  input  logic [AW-1:0]        wr0_addr,
  input  logic [XLEN-1:0]      wr0_data,
  input  logic                 wr1_en,
  input  logic [AW-1:0]        wr1_addr,
  input  logic [XLEN-1:0]      wr1_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 flush,
  output logic [AW:0]          busy_count
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr0_ok, wr1_ok;

  assign wr0_ok = wr0_en && !(ZERO_REG != 0 && wr0_addr == ZERO_ADDR);
  assign wr1_ok = wr1_en && !(ZERO_REG != 0 && wr1_addr == ZERO_ADDR);

  // wr1 is applied last so it wins on a same-register collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      if (wr0_ok) mem_q[wr0_addr] <= wr0_data;
      if (wr1_ok) mem_q[wr1_addr] <= wr1_data;
    end
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG),
    .AW      (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .flush     (flush),
    .busy      (busy),
    .busy_count(busy_count)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;
    logic            hit0, hit1, is_zero;

    assign addr    = rd_addr[i*AW +: AW];
    assign hit0    = wr0_en && wr0_addr == addr;
    assign hit1    = wr1_en && wr1_addr == addr;
    assign is_zero = ZERO_REG != 0 && addr == ZERO_ADDR;

    always_comb begin
      data = mem_q[addr];
      bsy  = busy[addr];
      if (BYPASS != 0) begin
        if (hit1)      data = wr1_data;
        else if (hit0) data = wr0_data;
        // a producer writing back this cycle resolves the hazard now
        if (hit0 || hit1) bsy = 1'b0;
      end
      if (is_zero) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = bsy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic compared every cycle against an array-based reference model.
module tb_reg_file_sb;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic              wr0_en, wr1_en, alloc_en, flush;
  regaddr_t          wr0_addr, wr1_addr, alloc_addr;
  logic [XLEN-1:0]   wr0_data, wr1_data;
  logic [AW:0]       busy_count;

  int total = 0;
  int bad = 0;

  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];

  reg_file_sb dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .alloc_en  (alloc_en),
    .alloc_addr(alloc_addr),
    .flush     (flush),
    .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic write_hits(input int a);
    return (wr0_en && int'(wr0_addr) == a) || (wr1_en && int'(wr1_addr) == a);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a);
    if (a == 0) return '0;
    if (wr1_en && int'(wr1_addr) == a) return wr1_data;
    if (wr0_en && int'(wr0_addr) == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !write_hits(a);
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Reference model: architectural state changes at each edge, cleared by reset.
  always @(posedge clk or posedge reset) begin : model_upd
    bit nb;
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        nb = m_busy[r];
        if (flush) nb = 1'b0;
        else if (alloc_en && int'(alloc_addr) == r && r != 0) nb = 1'b1;
        else if (write_hits(r)) nb = 1'b0;
        m_busy[r] <= nb;
      end
      if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] <= wr1_data;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]),
            64'(exp_data(int'(rd_addr[i*AW +: AW]))));
      check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]),
            64'(exp_busy(int'(rd_addr[i*AW +: AW]))));
    end
    check("busy_count", 64'(busy_count), 64'(exp_count()));
  end

  task automatic idle();
    wr0_en = 0; wr1_en = 0; alloc_en = 0; flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic regaddr_t rand_addr();
    if ($urandom_range(0, 3) == 0) return regaddr_t'($urandom_range(0, NREGS-1));
    return regaddr_t'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1; rd_addr = '0; idle();
    wr0_addr = '0; wr1_addr = '0; alloc_addr = '0; wr0_data = '0; wr1_data = '0;
    #12;
    check("reset_rd_data", 64'(rd_data), 64'd0);
    check("reset_count", 64'(busy_count), 64'd0);
    reset = 0;
    cyc();

    // async reset in mid-cycle wipes a freshly written register
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    cyc(); idle(); rd_addr = {5'd0, 5'd5};
    #1 check("x5_written", 64'(rd_data[31:0]), 64'hDEADBEEF);
    #1 reset = 1;
    #1 check("x5_after_reset", 64'(rd_data[31:0]), 64'd0);
    check("count_after_reset", 64'(busy_count), 64'd0);
    #2 reset = 0;
    cyc();

    // same-register collision: wr1 wins, forwarded and stored
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22;
    rd_addr = {5'd0, 5'd3};
    #1 check("bypass_wr1_wins", 64'(rd_data[31:0]), 64'h22);
    cyc(); idle();
    #1 check("stored_x3", 64'(rd_data[31:0]), 64'h22);

    // x0 ignores writes and allocation
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hFFFFFFFF;
    alloc_en = 1; alloc_addr = 0; rd_addr = {5'd0, 5'd0};
    #1 check("x0_bypass", 64'(rd_data[31:0]), 64'd0);
    check("x0_busy", 64'(rd_busy[0]), 64'd0);
    cyc(); idle();
    #1 check("x0_stored", 64'(rd_data[31:0]), 64'd0);
    check("x0_count", 64'(busy_count), 64'd0);

    // allocate/writeback lifecycle on x7
    alloc_en = 1; alloc_addr = 7;
    cyc(); idle(); rd_addr = {5'd7, 5'd0};
    #1 check("x7_busy", 64'(rd_busy[1]), 64'd1);
    check("x7_count", 64'(busy_count), 64'd1);
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h55;
    #1 check("x7_wb_busy", 64'(rd_busy[1]), 64'd0);
    check("x7_wb_data", 64'(rd_data[63:32]), 64'h55);
    cyc(); idle();
    #1 check("x7_count_clear", 64'(busy_count), 64'd0);

    // re-allocate while writing back: new producer keeps x9 busy
    alloc_en = 1; alloc_addr = 9;
    cyc();
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'hABCD;
    cyc(); idle(); rd_addr = {5'd0, 5'd9};
    #1 check("x9_data", 64'(rd_data[31:0]), 64'hABCD);
    check("x9_busy", 64'(rd_busy[0]), 64'd1);
    check("x9_count", 64'(busy_count), 64'd1);
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'hABCD;
    cyc(); idle();

    // flush beats a same-cycle alloc and keeps data
    alloc_en = 1; alloc_addr = 1; cyc();
    alloc_addr = 2; cyc();
    alloc_addr = 4; cyc();
    idle();
    #1 check("count_three", 64'(busy_count), 64'd3);
    flush = 1; alloc_en = 1; alloc_addr = 6;
    cyc(); idle(); rd_addr = {5'd6, 5'd3};
    #1 check("flush_count", 64'(busy_count), 64'd0);
    check("flush_x6_busy", 64'(rd_busy[1]), 64'd0);
    check("flush_x3_data", 64'(rd_data[31:0]), 64'h22);
    rd_addr = {5'd1, 5'd7};
    #1 check("flush_x7_data", 64'(rd_data[31:0]), 64'h55);
    check("flush_x1_busy", 64'(rd_busy[1]), 64'd0);

    // randomized traffic checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      cyc();
      wr0_en = $urandom_range(0, 1) == 0;
      wr0_addr = rand_addr(); wr0_data = $urandom;
      wr1_en = $urandom_range(0, 2) == 0;
      wr1_addr = rand_addr(); wr1_data = $urandom;
      alloc_en = $urandom_range(0, 1) == 0;
      alloc_addr = rand_addr();
      flush = $urandom_range(0, 40) == 0;
      rd_addr = {rand_addr(), rand_addr()};
      if ($urandom_range(0, 600) == 0) begin
        #2 reset = 1;
        #1 reset = 0;
      end
    end
    cyc(); idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
